dcache_snoop_responder: RTL and testbench

// Per-core snoop responder for the MSI-coherent L1 dcache: the cache-side end of the

---
 rtl/coherence_pkg.sv | 33 +++
 rtl/dcache_tag_store.sv | 78 +++++++
 rtl/dcache_snoop_responder.sv | 166 ++++++++++++++++
 tb/tb_dcache_snoop_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coherence_pkg.sv
// Shared MSI coherence types for the L1 dcache snoop path.
// Holds the MSI state enum, the snoop FSM encoding and address-field widths.
package coherence_pkg;

    typedef enum logic [1:0] {
        MSI_I = 2'd0,
        MSI_S = 2'd1,
        MSI_M = 2'd2
    } msi_t;

    typedef enum logic [2:0] {
        SNP_IDLE   = 3'd0,
        SNP_LOOKUP = 3'd1,
        SNP_FLUSH0 = 3'd2,
        SNP_FLUSH1 = 3'd3,
        SNP_UPDATE = 3'd4,
        SNP_HOLD   = 3'd5
    } snp_state_t;

    localparam int ADDR_W    = 32;
    localparam int WORD_BIT  = 2;
    localparam int BLK_OFF_W = 3;

    // A snooped valid frame always loses ownership: BusRdX kills it,
    // BusRd leaves a shared copy.
    function automatic msi_t msi_after_snoop(msi_t cur, logic inv);
        if (cur == MSI_I) begin
            return MSI_I;
        end
        return inv ? MSI_I : MSI_S;
    endfunction

endpackage

// File: rtl/dcache_tag_store.sv
// Tag + MSI state arrays of the dcache with one write port and two
// combinational compare ports (snoop side and core side).
// Ports: CLK/RST; wr_* write port; snp_set/snp_tag -> snp_hit/way/st;
// core_set/core_tag -> core_hit/way/st. Lowest matching way wins.
module dcache_tag_store
    import coherence_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    localparam int SET_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int TAG_W = ADDR_W - BLK_OFF_W - SET_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [SET_W-1:0] wr_set,
    input  logic [WAY_W-1:0] wr_way,
    input  logic [TAG_W-1:0] wr_tag,
    input  msi_t             wr_st,
    input  logic [SET_W-1:0] snp_set,
    input  logic [TAG_W-1:0] snp_tag,
    output logic             snp_hit,
    output logic [WAY_W-1:0] snp_way,
    output msi_t             snp_st,
    input  logic [SET_W-1:0] core_set,
    input  logic [TAG_W-1:0] core_tag,
    output logic             core_hit,
    output logic [WAY_W-1:0] core_way,
    output msi_t             core_st
);

    msi_t             st_q  [SETS][WAYS];
    logic [TAG_W-1:0] tag_q [SETS][WAYS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    st_q[s][w]  <= MSI_I;
                    tag_q[s][w] <= '0;
                end
            end
        end else if (wr_en) begin
            st_q[wr_set][wr_way]  <= wr_st;
            tag_q[wr_set][wr_way] <= wr_tag;
        end
    end

    always_comb begin
        snp_hit = 1'b0;
        snp_way = '0;
        snp_st  = MSI_I;
        for (int w = 0; w < WAYS; w++) begin
            if (!snp_hit && st_q[snp_set][w] != MSI_I &&
                tag_q[snp_set][w] == snp_tag) begin
                snp_hit = 1'b1;
                snp_way = WAY_W'(w);
                snp_st  = st_q[snp_set][w];
            end
        end
    end

    always_comb begin
        core_hit = 1'b0;
        core_way = '0;
        core_st  = MSI_I;
        for (int w = 0; w < WAYS; w++) begin
            if (!core_hit && st_q[core_set][w] != MSI_I &&
                tag_q[core_set][w] == core_tag) begin
                core_hit = 1'b1;
                core_way = WAY_W'(w);
                core_st  = st_q[core_set][w];
            end
        end
    end

endmodule

// File: rtl/dcache_snoop_responder.sv
// Cache-side snoop responder of the MSI L1 dcache: answers controller snoops
// with ccwrite, flushes Modified blocks word-by-word on dstore, downgrades state.
// Ports: CLK/RST; ccwait/ccinv/ccsnoopaddr/dwait in; snp_ccwrite/dstore/snp_busy
// out; snp_word_idx/snp_word_rdata data-array read; core_upd_* write; core_lk_* lookup.
module dcache_snoop_responder
    import coherence_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    localparam int SET_W = $clog2(SETS),
    localparam int WB    = $clog2(WAYS),
    localparam int WAY_W = (WAYS > 1) ? WB : 1,
    localparam int TAG_W = ADDR_W - BLK_OFF_W - SET_W,
    localparam int IDX_W = SET_W + WB + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ccwait,
    input  logic             ccinv,
    input  logic [31:0]      ccsnoopaddr,
    input  logic             dwait,
    output logic             snp_ccwrite,
    output logic [31:0]      dstore,
    output logic             snp_busy,
    output logic [IDX_W-1:0] snp_word_idx,
    input  logic [31:0]      snp_word_rdata,
    input  logic             core_upd_en,
    input  logic [SET_W-1:0] core_upd_set,
    input  logic [WAY_W-1:0] core_upd_way,
    input  logic [TAG_W-1:0] core_upd_tag,
    input  logic [1:0]       core_upd_st,
    input  logic [31:0]      core_lk_addr,
    output logic             core_lk_hit,
    output logic [WAY_W-1:0] core_lk_way,
    output logic [1:0]       core_lk_st
);

    snp_state_t       state_q;
    logic [TAG_W-1:0] cap_tag_q;
    logic [SET_W-1:0] cap_set_q;
    logic             cap_inv_q;
    logic [WAY_W-1:0] hit_way_q;
    msi_t             hit_st_q;

    logic             snp_hit;
    logic [WAY_W-1:0] snp_way;
    msi_t             snp_st;
    msi_t             lk_st;
    logic             flushing;
    logic             upd_snoop;
    logic             wr_en;
    logic [SET_W-1:0] wr_set;
    logic [WAY_W-1:0] wr_way;
    logic [TAG_W-1:0] wr_tag;
    msi_t             wr_st;
    logic [5:0]       unused_addr_bits;

    // Block offset bits never select anything: whole blocks are flushed.
    assign unused_addr_bits = {ccsnoopaddr[2:0], core_lk_addr[2:0]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= SNP_IDLE;
            cap_tag_q <= '0;
            cap_set_q <= '0;
            cap_inv_q <= 1'b0;
            hit_way_q <= '0;
            hit_st_q  <= MSI_I;
        end else begin
            unique case (state_q)
                SNP_IDLE: begin
                    if (ccwait) begin
                        state_q   <= SNP_LOOKUP;
                        cap_tag_q <= ccsnoopaddr[31:BLK_OFF_W+SET_W];
                        cap_set_q <= ccsnoopaddr[BLK_OFF_W+SET_W-1:BLK_OFF_W];
                        cap_inv_q <= ccinv;
                    end
                end
                SNP_LOOKUP: begin
                    hit_way_q <= snp_way;
                    hit_st_q  <= snp_hit ? snp_st : MSI_I;
                    if (!ccwait) begin
                        state_q <= SNP_IDLE;
                    end else if (snp_hit && snp_st == MSI_M) begin
                        state_q <= SNP_FLUSH0;
                    end else begin
                        state_q <= SNP_UPDATE;
                    end
                end
                SNP_FLUSH0: begin
                    if (!ccwait) begin
                        state_q <= SNP_IDLE;
                    end else if (!dwait) begin
                        state_q <= SNP_FLUSH1;
                    end
                end
                SNP_FLUSH1: begin
                    if (!ccwait) begin
                        state_q <= SNP_IDLE;
                    end else if (!dwait) begin
                        state_q <= SNP_UPDATE;
                    end
                end
                SNP_UPDATE: state_q <= SNP_HOLD;
                SNP_HOLD: begin
                    if (!ccwait) begin
                        state_q <= SNP_IDLE;
                    end
                end
                default: state_q <= SNP_IDLE;
            endcase
        end
    end

    assign flushing = (state_q == SNP_FLUSH0) || (state_q == SNP_FLUSH1);

    // ccwrite answers in the LOOKUP cycle itself; a dropped ccwait
    // silences the bus at once rather than a cycle later.
    assign snp_ccwrite = ccwait &&
        (flushing || (state_q == SNP_LOOKUP && snp_hit && snp_st == MSI_M));
    assign dstore   = (ccwait && flushing) ? snp_word_rdata : '0;
    assign snp_busy = (state_q != SNP_IDLE) || ccwait;

    generate
        if (WB == 0) begin : g_idx_dm
            assign snp_word_idx = {cap_set_q, state_q == SNP_FLUSH1};
        end else begin : g_idx_sa
            assign snp_word_idx =
                {cap_set_q, hit_way_q[WB-1:0], state_q == SNP_FLUSH1};
        end
    endgenerate

    assign upd_snoop = (state_q == SNP_UPDATE) && (hit_st_q != MSI_I);
    assign wr_en     = upd_snoop || (core_upd_en && !snp_busy);
    assign wr_set    = upd_snoop ? cap_set_q : core_upd_set;
    assign wr_way    = upd_snoop ? hit_way_q : core_upd_way;
    assign wr_tag    = upd_snoop ? cap_tag_q : core_upd_tag;
    assign wr_st     = upd_snoop ? msi_after_snoop(hit_st_q, cap_inv_q)
                                 : msi_t'(core_upd_st);

    dcache_tag_store #(
        .SETS(SETS),
        .WAYS(WAYS)
    ) u_tags (
        .CLK      (CLK),
        .RST      (RST),
        .wr_en    (wr_en),
        .wr_set   (wr_set),
        .wr_way   (wr_way),
        .wr_tag   (wr_tag),
        .wr_st    (wr_st),
        .snp_set  (cap_set_q),
        .snp_tag  (cap_tag_q),
        .snp_hit  (snp_hit),
        .snp_way  (snp_way),
        .snp_st   (snp_st),
        .core_set (core_lk_addr[BLK_OFF_W+SET_W-1:BLK_OFF_W]),
        .core_tag (core_lk_addr[31:BLK_OFF_W+SET_W]),
        .core_hit (core_lk_hit),
        .core_way (core_lk_way),
        .core_st  (lk_st)
    );

    assign core_lk_st = lk_st;

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Self-checking bench for dcache_snoop_responder: directed snoop scenarios
// followed by random snoops/core writes checked against an MSI frame model.
module tb_dcache_snoop_responder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ccwait;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;
    logic        dwait;
    logic        snp_ccwrite;
    logic [31:0] dstore;
    logic        snp_busy;
    logic [4:0]  snp_word_idx;
    logic [31:0] snp_word_rdata;
    logic        core_upd_en;
    logic [2:0]  core_upd_set;
    logic [0:0]  core_upd_way;
    logic [25:0] core_upd_tag;
    logic [1:0]  core_upd_st;
    logic [31:0] core_lk_addr;
    logic        core_lk_hit;
    logic [0:0]  core_lk_way;
    logic [1:0]  core_lk_st;

    dcache_snoop_responder dut (
        .CLK            (CLK),
        .RST            (RST),
        .ccwait         (ccwait),
        .ccinv          (ccinv),
        .ccsnoopaddr    (ccsnoopaddr),
        .dwait          (dwait),
        .snp_ccwrite    (snp_ccwrite),
        .dstore         (dstore),
        .snp_busy       (snp_busy),
        .snp_word_idx   (snp_word_idx),
        .snp_word_rdata (snp_word_rdata),
        .core_upd_en    (core_upd_en),
        .core_upd_set   (core_upd_set),
        .core_upd_way   (core_upd_way),
        .core_upd_tag   (core_upd_tag),
        .core_upd_st    (core_upd_st),
        .core_lk_addr   (core_lk_addr),
        .core_lk_hit    (core_lk_hit),
        .core_lk_way    (core_lk_way),
        .core_lk_st     (core_lk_st)
    );

    always #5 CLK = ~CLK;

    // Data array: index = set*4 + way*2 + word.
    logic [31:0] dmem [32];
    assign snp_word_rdata = dmem[snp_word_idx];

    // Frame model: state 0=I 1=S 2=M.
    int          mst  [8][2];
    logic [25:0] mtag [8][2];
    int          passed = 0;
    int          total  = 0;
    logic [25:0] pool [4];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] mk_addr(input int s, input logic [25:0] t,
                                            input bit w);
        logic [2:0] s3;
        s3 = s[2:0];
        return {t, s3, w, 2'b00};
    endfunction

    task automatic mlook(input logic [31:0] a, output bit hit,
                         output int way, output int st);
        int s;
        s   = int'(a[5:3]);
        hit = 1'b0;
        way = 0;
        st  = 0;
        for (int w = 0; w < 2; w++) begin
            if (!hit && mst[s][w] != 0 && mtag[s][w] == a[31:6]) begin
                hit = 1'b1;
                way = w;
                st  = mst[s][w];
            end
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 2; w++) begin
                mst[s][w]  = 0;
                mtag[s][w] = '0;
            end
        end
    endtask

    task automatic core_write(input int s, input int w,
                              input logic [25:0] t, input int st);
        core_upd_en  = 1'b1;
        core_upd_set = s[2:0];
        core_upd_way = w[0:0];
        core_upd_tag = t;
        core_upd_st  = st[1:0];
        tick();
        core_upd_en = 1'b0;
        mst[s][w]   = st;
        mtag[s][w]  = t;
    endtask

    task automatic lk_check(input string nm, input logic [31:0] a);
        bit hit;
        int way;
        int st;
        core_lk_addr = a;
        mlook(a, hit, way, st);
        @(negedge CLK);
        chk({nm, "_hit"}, 32'(core_lk_hit), 32'(hit));
        chk({nm, "_st"}, 32'(core_lk_st), 32'(st));
        if (hit) chk({nm, "_way"}, 32'(core_lk_way), 32'(way));
        tick();
    endtask

    task automatic do_snoop(input string nm, input logic [31:0] a,
                            input bit inv, input int hold, input bit abort);
        bit hit;
        int way;
        int st;
        int s;
        int base;
        mlook(a, hit, way, st);
        s    = int'(a[5:3]);
        base = s * 4 + way * 2;
        ccwait      = 1'b1;
        ccsnoopaddr = a;
        ccinv       = inv;
        dwait       = 1'($urandom);
        @(negedge CLK);
        chk({nm, "_busy_rise"}, 32'(snp_busy), 32'd1);
        chk({nm, "_ccw_idle"}, 32'(snp_ccwrite), 32'd0);
        tick();
        ccinv       = ~inv;
        ccsnoopaddr = $urandom;
        @(negedge CLK);
        chk({nm, "_ccw_lookup"}, 32'(snp_ccwrite), 32'(hit && st == 2));
        tick();
        if (hit && st == 2) begin
            for (int k = 0; k < hold; k++) begin
                dwait = 1'b1;
                @(negedge CLK);
                chk({nm, "_d0_wait"}, dstore, dmem[base]);
                chk({nm, "_ccw_wait"}, 32'(snp_ccwrite), 32'd1);
                tick();
            end
            if (abort) begin
                ccwait = 1'b0;
                dwait  = 1'b1;
                @(negedge CLK);
                chk({nm, "_ccw_abort"}, 32'(snp_ccwrite), 32'd0);
                tick();
                @(negedge CLK);
                chk({nm, "_busy_abort"}, 32'(snp_busy), 32'd0);
                tick();
                lk_check({nm, "_after"}, a);
                return;
            end
            dwait = 1'b0;
            @(negedge CLK);
            chk({nm, "_d0"}, dstore, dmem[base]);
            tick();
            @(negedge CLK);
            chk({nm, "_d1"}, dstore, dmem[base+1]);
            chk({nm, "_ccw_f1"}, 32'(snp_ccwrite), 32'd1);
            tick();
        end
        tick();
        @(negedge CLK);
        chk({nm, "_ccw_hold"}, 32'(snp_ccwrite), 32'd0);
        chk({nm, "_busy_hold"}, 32'(snp_busy), 32'd1);
        tick();
        ccwait = 1'b0;
        @(negedge CLK);
        chk({nm, "_busy_exit"}, 32'(snp_busy), 32'd1);
        tick();
        @(negedge CLK);
        chk({nm, "_busy_idle"}, 32'(snp_busy), 32'd0);
        if (hit) mst[s][way] = inv ? 0 : 1;
        tick();
        lk_check({nm, "_after"}, a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [25:0] taga;
        logic [31:0] a;
        int          r;
        taga = 26'h2A5_1234;
        pool[0] = taga;
        pool[1] = 26'h000_0011;
        pool[2] = 26'h3FF_0000;
        pool[3] = 26'h155_5555;
        for (int i = 0; i < 32; i++) dmem[i] = $urandom;
        dmem[3*4+1*2+0] = 32'hA5A5_0001;
        dmem[3*4+1*2+1] = 32'hA5A5_0002;
        model_clear();
        RST = 1'b1;
        ccwait = 1'b0;
        ccinv = 1'b0;
        ccsnoopaddr = '0;
        dwait = 1'b1;
        core_upd_en = 1'b0;
        core_upd_set = '0;
        core_upd_way = '0;
        core_upd_tag = '0;
        core_upd_st = '0;
        core_lk_addr = '0;
        tick();
        tick();
        RST = 1'b0;

        core_write(1, 0, pool[1], 2);
        core_write(4, 1, pool[2], 1);
        lk_check("preload", mk_addr(1, pool[1], 0));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_clear();
        @(negedge CLK);
        chk("rst_ccwrite", 32'(snp_ccwrite), 32'd0);
        chk("rst_dstore", dstore, 32'd0);
        chk("rst_busy", 32'(snp_busy), 32'd0);
        tick();
        lk_check("rst_f1", mk_addr(1, pool[1], 0));
        lk_check("rst_f4", mk_addr(4, pool[2], 1));
        for (int s = 0; s < 8; s++) lk_check("rst_tag0", mk_addr(s, '0, 0));

        core_write(3, 0, pool[3], 1);
        core_write(3, 1, taga, 2);
        do_snoop("busrd_m", mk_addr(3, taga, 0), 1'b0, 0, 1'b0);
        do_snoop("busrdx_s", mk_addr(3, taga, 1), 1'b1, 0, 1'b0);
        do_snoop("miss", mk_addr(6, pool[1], 0), 1'b1, 0, 1'b0);
        lk_check("miss_w0", mk_addr(3, pool[3], 0));

        core_write(3, 1, taga, 2);
        do_snoop("rdx_wait", mk_addr(3, taga, 0), 1'b1, 5, 1'b0);

        ccwait       = 1'b1;
        ccsnoopaddr  = mk_addr(6, 26'h3, 0);
        ccinv        = 1'b0;
        core_upd_en  = 1'b1;
        core_upd_set = 3'd5;
        core_upd_way = 1'b0;
        core_upd_tag = 26'h155;
        core_upd_st  = 2'd1;
        core_lk_addr = mk_addr(5, 26'h155, 0);
        @(negedge CLK);
        chk("upd_busy", 32'(snp_busy), 32'd1);
        tick();
        tick();
        tick();
        @(negedge CLK);
        chk("upd_ignored", 32'(core_lk_hit), 32'd0);
        tick();
        ccwait = 1'b0;
        tick();
        @(negedge CLK);
        chk("upd_idle", 32'(snp_busy), 32'd0);
        tick();
        core_upd_en = 1'b0;
        mst[5][0]  = 1;
        mtag[5][0] = 26'h155;
        lk_check("upd_applied", mk_addr(5, 26'h155, 0));

        core_write(3, 1, taga, 2);
        do_snoop("abort", mk_addr(3, taga, 0), 1'b0, 1, 1'b1);

        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
                core_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                           pool[$urandom_range(0, 3)], int'($urandom_range(0, 2)));
            end else begin
                a = mk_addr(int'($urandom_range(0, 7)), pool[$urandom_range(0, 3)],
                            1'($urandom));
                do_snoop("rnd", a, 1'($urandom), int'($urandom_range(0, 3)),
                         ($urandom_range(0, 7) == 0));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
